// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache geometry and refill FSM encoding.
// Refill engine and its sub-blocks import this so address slicing stays consistent.
package cache_refill_ctrl_pkg;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORDS_LINE = 4;
  localparam int SETS       = 8;
  localparam int WAYS       = 4;

  localparam int OFF_W  = $clog2(WORDS_LINE * DATA_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORD_W = $clog2(WORDS_LINE);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
endpackage

// File: rtl/cache_refill_ctrl_beat_ctr.sv
// Wrapping beat counter for line refills; last flags the final word of the line.
// Counts on en, held at zero by clr, no backpressure of its own.
module refill_beat_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

  assign last = &cnt;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill engine: requests a line, streams beats into the data array, installs the tag.
// Minimum miss-to-done latency 3+WORDS_LINE cycles; waits indefinitely on mem_gnt and mem_rvalid.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [WAY_W-1:0]  victim_way,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refill_we,
  output logic [IDX_W-1:0]  refill_set,
  output logic [WAY_W-1:0]  refill_way,
  output logic [WORD_W-1:0] refill_word,
  output logic [DATA_W-1:0] refill_data,
  output logic              tag_we,
  output logic [TAG_W-1:0]  tag_data,
  output logic              stall,
  output logic              refill_done
);

  logic [2:0]        state;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  set_q;
  logic [WAY_W-1:0]  way_q;
  logic [WORD_W-1:0] beat_cnt;
  logic              beat_last;
  logic              beat_take;

  // Byte-offset bits never matter: refills are always whole lines.
  logic unused_off;
  assign unused_off = ^miss_addr[OFF_W-1:0];

  assign beat_take = (state == S_FILL) && mem_rvalid;

  refill_beat_ctr #(.W(WORD_W)) u_beat_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_IDLE),
    .en    (beat_take),
    .cnt   (beat_cnt),
    .last  (beat_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tag_q       <= '0;
      set_q       <= '0;
      way_q       <= '0;
      mem_req     <= 1'b0;
      stall       <= 1'b0;
      refill_we   <= 1'b0;
      refill_word <= '0;
      refill_data <= '0;
      tag_we      <= 1'b0;
      refill_done <= 1'b0;
    end else begin
      refill_we   <= 1'b0;
      tag_we      <= 1'b0;
      refill_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss) begin
            tag_q   <= miss_addr[ADDR_W-1 -: TAG_W];
            set_q   <= miss_addr[OFF_W +: IDX_W];
            way_q   <= victim_way;
            mem_req <= 1'b1;
            stall   <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            refill_we   <= 1'b1;
            refill_word <= beat_cnt;
            refill_data <= mem_rdata;
            if (beat_last) begin
              tag_we <= 1'b1;
              state  <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          refill_done <= 1'b1;
          stall       <= 1'b0;
          state       <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          stall   <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Latched miss fields feed the memory address and the array ports directly.
  assign mem_addr   = {tag_q, set_q, {OFF_W{1'b0}}};
  assign refill_set = set_q;
  assign refill_way = way_q;
  assign tag_data   = tag_q;

endmodule
